online_mult_serial: RTL and testbench



---
 rtl/olm_pkg.sv | 33 +++
 rtl/online_mult_serial_csa42_row.sv | 34 +++
 rtl/online_mult_serial.sv | 191 +++++++++++++++++++
 tb/tb_online_mult_serial.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/olm_pkg.sv
// Shared definitions for the radix-2 online multiplier: signed-digit
// encoding, digit decode helper, selection thresholds and FSM states.
package olm_pkg;

    localparam logic [1:0] SD_POS  = 2'b10;
    localparam logic [1:0] SD_NEG  = 2'b01;
    localparam logic [1:0] SD_ZERO = 2'b00;

    // Online delay supported by the fixed t=2 selection function.
    localparam int DELTA_DEFAULT = 3;

    // Selection estimate keeps this many fractional bits.
    localparam int EST_FRAC = 2;

    // Thresholds in units of 2^-EST_FRAC: +1/2 and -1/2.
    localparam int SEL_POS_TH = 2;
    localparam int SEL_NEG_TH = -2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Decode a {p,n} digit; the redundant 2'b11 pattern means zero.
    function automatic logic signed [1:0] sd_val(input logic [1:0] d);
        case (d)
            SD_POS:  return 2'sb01;
            SD_NEG:  return 2'sb11;
            default: return 2'sb00;
        endcase
    endfunction

endpackage

// File: rtl/online_mult_serial_csa42_row.sv
// WL-bit 4:2 carry-save row built from two full-adder layers per column.
// The first-layer carry h ripples one column left into the second layer;
// cin1 enters as column 0's h input and cin2 as the carry vector's LSB,
// which is where the +1 of a two's-complement negation is injected.
// sum + carry == a + b + c + d + cin1 + cin2 (mod 2^WL).
module csa42_row #(
    parameter int WL = 14
) (
    input  logic [WL-1:0] a,
    input  logic [WL-1:0] b,
    input  logic [WL-1:0] c,
    input  logic [WL-1:0] d,
    input  logic          cin1,
    input  logic          cin2,
    output logic [WL-1:0] sum,
    output logic [WL-1:0] carry
);

    logic [WL-1:0] s1;
    logic [WL-2:0] h;
    logic [WL-1:0] h_in;
    logic [WL-2:0] cy;

    // Two full-adder layers; the top column's outgoing carries fall off the row.
    always_comb begin
        s1    = a ^ b ^ c;
        h     = (a[WL-2:0] & b[WL-2:0]) | (a[WL-2:0] & c[WL-2:0]) | (b[WL-2:0] & c[WL-2:0]);
        h_in  = {h, cin1};
        sum   = s1 ^ d ^ h_in;
        cy    = (s1[WL-2:0] & d[WL-2:0]) | (s1[WL-2:0] & h_in[WL-2:0]) | (d[WL-2:0] & h_in[WL-2:0]);
        carry = {cy, cin2};
    end

endmodule

// File: rtl/online_mult_serial.sv
// Radix-2 signed-digit online multiplier, MSD-first, one digit pair per
// accepted beat, one product digit per step after an online delay of DELTA.
// The residual is kept in carry-save form and updated by a 4:2 CSA row.
// Optional macro OLM_RESIDUAL_OUT_EN exposes the final residual pair on
// res_s/res_c.
module online_mult_serial
    import olm_pkg::*;
#(
    parameter int N     = 8,
    parameter int DELTA = DELTA_DEFAULT,   // selection is sized for 3 only
    parameter int WL    = N + DELTA + 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    x_dig,
    input  logic [1:0]    y_dig,
    output logic          out_valid,
    output logic [1:0]    z_dig,
    output logic          busy,
    output logic          done
`ifdef OLM_RESIDUAL_OUT_EN
    ,
    output logic [WL-1:0] res_s,
    output logic [WL-1:0] res_c
`endif
);

    // Fractional bits of the residual; the operand LSB (2^-N) scaled by
    // 2^-DELTA lands exactly on residual bit 0.
    localparam int F  = N + DELTA;
    localparam int JW = $clog2(N + DELTA) + 1;
    localparam logic [JW-1:0] J_N     = JW'(N);
    localparam logic [JW-1:0] J_DELTA = JW'(DELTA);
    localparam logic [JW-1:0] J_LAST  = JW'(N + DELTA - 1);
    localparam logic [N:0]    ONE     = (N+1)'(1);

    state_t state, state_next;

    logic [JW-1:0]        j;
    logic signed [N:0]    xr, yr;
    // The residual MSB is never needed: |W| < 1 fits two integer bits and
    // the doubling shift discards the top bit anyway.
    logic [WL-2:0]        ws, wc;

    logic                 j_lt_n, step, last_step;
    logic signed [1:0]    xs, ys, z_s;
    logic [JW-1:0]        sh;
    logic [N:0]           unit;
    logic signed [N:0]    x_next, y_next;
    logic [WL-1:0]        x_term, y_term;
    logic                 x_neg, y_neg;
    logic [WL-1:0]        vs, vc;
    logic signed [4:0]    vhat;
    logic [1:0]           z_code;
    logic [WL-2:0]        ws_next;

    assign j_lt_n    = (j < J_N);
    assign step      = (state == RUN) && (j_lt_n ? in_valid : 1'b1);
    assign last_step = step && (j == J_LAST);
    assign in_ready  = (state == RUN) && j_lt_n;
    assign busy      = (state == RUN) || done;

    // FSM next-state: IDLE waits for start, RUN ends on the last iteration.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Operand update: append this step's digits at weight 2^-(j+1); past
    // the last input digit the operands stay frozen (zero digits).
    always_comb begin
        xs     = j_lt_n ? sd_val(x_dig) : 2'sb00;
        ys     = j_lt_n ? sd_val(y_dig) : 2'sb00;
        sh     = J_N - JW'(1) - j;
        unit   = j_lt_n ? (ONE << sh) : '0;
        y_next = yr;
        x_next = xr;
        if (ys > 2'sb00)      y_next = yr + unit;
        else if (ys < 2'sb00) y_next = yr - unit;
        if (xs > 2'sb00)      x_next = xr + unit;
        else if (xs < 2'sb00) x_next = xr - unit;
    end

    // Partial-product terms x*Y[j+1] and y*X[j]; negation is ones'
    // complement here plus a carry-in on the CSA row.
    always_comb begin
        x_term = '0;
        x_neg  = 1'b0;
        y_term = '0;
        y_neg  = 1'b0;
        if (xs > 2'sb00) begin
            x_term = {{(WL-N-1){y_next[N]}}, y_next};
        end else if (xs < 2'sb00) begin
            x_term = ~{{(WL-N-1){y_next[N]}}, y_next};
            x_neg  = 1'b1;
        end
        if (ys > 2'sb00) begin
            y_term = {{(WL-N-1){xr[N]}}, xr};
        end else if (ys < 2'sb00) begin
            y_term = ~{{(WL-N-1){xr[N]}}, xr};
            y_neg  = 1'b1;
        end
    end

    csa42_row #(.WL(WL)) u_row (
        .a     ({ws, 1'b0}),
        .b     ({wc, 1'b0}),
        .c     (x_term),
        .d     (y_term),
        .cin1  (x_neg),
        .cin2  (y_neg),
        .sum   (vs),
        .carry (vc)
    );

    // Digit selection from the truncated estimate, then W = V - z by
    // adjusting only the integer field of the sum vector.
    always_comb begin
        vhat   = $signed(vs[WL-1:F-EST_FRAC]) + $signed(vc[WL-1:F-EST_FRAC]);
        z_code = SD_ZERO;
        if (j >= J_DELTA) begin
            if (int'(vhat) >= SEL_POS_TH)     z_code = SD_POS;
            else if (int'(vhat) < SEL_NEG_TH) z_code = SD_NEG;
        end
        z_s     = sd_val(z_code);
        ws_next = {vs[WL-2:F] - $unsigned(z_s), vs[F-1:0]};
    end

    // Iteration state and registered outputs; a start in IDLE clears the
    // datapath, a stall leaves everything untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            j         <= '0;
            xr        <= '0;
            yr        <= '0;
            ws        <= '0;
            wc        <= '0;
            out_valid <= 1'b0;
            z_dig     <= SD_ZERO;
            done      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            if ((state == IDLE) && start) begin
                j  <= '0;
                xr <= '0;
                yr <= '0;
                ws <= '0;
                wc <= '0;
            end else if (step) begin
                j  <= j + JW'(1);
                xr <= x_next;
                yr <= y_next;
                ws <= ws_next;
                wc <= vc[WL-2:0];
                if (j >= J_DELTA) begin
                    out_valid <= 1'b1;
                    z_dig     <= z_code;
                end
                done <= last_step;
            end
        end
    end

`ifdef OLM_RESIDUAL_OUT_EN
    // Hold the full-width final residual pair from the done cycle onward.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_s <= '0;
            res_c <= '0;
        end else if (last_step) begin
            res_s <= {vs[WL-1:F] - {z_s[1], z_s}, vs[F-1:0]};
            res_c <= vc;
        end
    end
`endif

endmodule

// File: tb/tb_online_mult_serial.sv
// Self-checking bench for online_mult_serial: random and directed operand
// digit streams, checked against exact integer products and protocol rules.
`timescale 1ns/1ps
module tb_online_mult_serial;

    localparam int N     = 8;
    localparam int DELTA = 3;
    localparam int WL    = N + DELTA + 3;
    localparam int F     = N + DELTA;

    logic       clk = 1'b0;
    logic       rst_n, start, in_valid, in_ready, out_valid, busy, done;
    logic [1:0] x_dig, y_dig, z_dig;
`ifdef OLM_RESIDUAL_OUT_EN
    logic [WL-1:0] res_s, res_c;
`endif

    int checks = 0;
    int errors = 0;
    int xd[N];
    int yd[N];
    int saved[N];
    int zq[$];
    int done_total = 0, done_pos = 0, illegal_total = 0, run_total = 0;
    int last_base = 0;

    online_mult_serial #(.N(N), .DELTA(DELTA)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_dig     (x_dig),
        .y_dig     (y_dig),
        .out_valid (out_valid),
        .z_dig     (z_dig),
        .busy      (busy),
        .done      (done)
`ifdef OLM_RESIDUAL_OUT_EN
        ,
        .res_s     (res_s),
        .res_c     (res_c)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Digit encoder; zero is sent as 2'b00 or, sometimes, the redundant 2'b11.
    function automatic logic [1:0] enc(input int d);
        if (d > 0) return 2'b10;
        if (d < 0) return 2'b01;
        return ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
    endfunction

    function automatic int zget(input int idx);
        if (idx < zq.size()) return zq[idx];
        return 99;
    endfunction

    task automatic rand_ops();
        for (int k = 0; k < N; k++) begin
            xd[k] = int'($urandom_range(0, 2)) - 1;
            yd[k] = int'($urandom_range(0, 2)) - 1;
        end
    endtask

    // Output collector: product digits, done position, illegal codes, RUN cycles.
    always @(negedge clk) begin
        if (out_valid) begin
            if (z_dig == 2'b11) illegal_total++;
            zq.push_back(z_dig == 2'b10 ? 1 : (z_dig == 2'b01 ? -1 : 0));
        end
        if (done) begin
            done_total++;
            done_pos = zq.size();
        end
        if (busy && !done) run_total++;
    end

    // One full operation from xd/yd; ends at negedge+1 of the done cycle.
    task automatic run_op(input string tag, input bit b2b, input int stall_at, input int stall_len,
                          input int spurious_at, input bit exact, input longint exp_z);
        int base, dbase, rbase, ibase, i, stalled, guard;
        bit rdy;
        longint xv, yv, zv, err;
        base  = zq.size();
        dbase = done_total;
        rbase = run_total;
        ibase = illegal_total;
        last_base = base;
        if (!b2b) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        i = 0; stalled = 0; guard = 0;
        while (i < N && guard < 100) begin
            start = (i == spurious_at);
            if (i == stall_at && stalled < stall_len) begin
                in_valid = 1'b0;
                stalled++;
            end else begin
                in_valid = 1'b1;
                x_dig = enc(xd[i]);
                y_dig = enc(yd[i]);
            end
            rdy = in_ready;
            @(posedge clk); #1;
            if (in_valid && rdy) i++;
            else chk({tag, "_stall_ov"}, out_valid, 0);
            guard++;
        end
        start = 1'b0; in_valid = 1'b0; x_dig = 2'b00; y_dig = 2'b00;
        chk({tag, "_accepted"}, i, N);
        chk({tag, "_rdy_tail"}, in_ready, 0);
        guard = 0;
        while (!done && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({tag, "_done_seen"}, done, 1);
        chk({tag, "_busy_at_done"}, busy, 1);
`ifdef OLM_RESIDUAL_OUT_EN
        begin
            logic signed [WL-1:0] w;
            w = res_s + res_c;
            chk({tag, "_res_lt1"}, (w < (1 <<< F)) && (w > -(1 <<< F)), 1);
        end
`endif
        @(negedge clk); #1;
        chk({tag, "_ndig"}, zq.size() - base, N);
        chk({tag, "_done_cnt"}, done_total - dbase, 1);
        chk({tag, "_done_pos"}, done_pos - base, N);
        chk({tag, "_legal"}, illegal_total - ibase, 0);
        chk({tag, "_cycles"}, run_total - rbase, N + DELTA + stalled);
        xv = 0; yv = 0; zv = 0;
        for (int k = 0; k < N; k++) begin
            xv += longint'(xd[k]) * (longint'(1) << (N - 1 - k));
            yv += longint'(yd[k]) * (longint'(1) << (N - 1 - k));
            zv += longint'(zget(base + k)) * (longint'(1) << (N - 1 - k));
        end
        err = xv * yv - zv * (longint'(1) << N);
        chk({tag, "_acc"}, (err <= (longint'(1) << N)) && (err >= -(longint'(1) << N)), 1);
        if (exact) chk({tag, "_z"}, zv, exp_z);
    endtask

    initial begin
        int dbase;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; x_dig = 2'b00; y_dig = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_z_dig", z_dig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // All-zero operands: every digit zero.
        for (int k = 0; k < N; k++) begin xd[k] = 0; yd[k] = 0; end
        run_op("zero", 1'b0, -1, 0, -1, 1'b1, 0);
        for (int k = 0; k < N; k++) chk("zero_dig", zget(last_base + k), 0);

        // 1/2 * 1/2 = 1/4 exactly.
        for (int k = 0; k < N; k++) begin xd[k] = 0; yd[k] = 0; end
        xd[0] = 1; yd[0] = 1;
        run_op("half", 1'b0, -1, 0, -1, 1'b1, 64);

        // Maximum magnitudes, both signs.
        for (int k = 0; k < N; k++) begin xd[k] = 1; yd[k] = 1; end
        run_op("maxpp", 1'b0, -1, 0, -1, 1'b0, 0);
        for (int k = 0; k < N; k++) begin xd[k] = 1; yd[k] = -1; end
        run_op("maxpn", 1'b0, -1, 0, -1, 1'b0, 0);

        // Stall of 3 cycles at j=4 must not change the digit stream.
        rand_ops();
        run_op("nostall", 1'b0, -1, 0, -1, 1'b0, 0);
        for (int k = 0; k < N; k++) saved[k] = zget(last_base + k);
        run_op("stall", 1'b0, 4, 3, -1, 1'b0, 0);
        for (int k = 0; k < N; k++) chk("stall_seq", zget(last_base + k), saved[k]);

        // Reset asserted at j=6 aborts without done.
        rand_ops();
        dbase = done_total;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; x_dig = enc(xd[k]); y_dig = enc(yd[k]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_z_dig", z_dig, 0);
        @(negedge clk); #1;
        chk("abort_no_done", done_total - dbase, 0);

        // 3/4 * -1/2 = -0.375 after the abort.
        for (int k = 0; k < N; k++) begin xd[k] = 0; yd[k] = 0; end
        xd[0] = 1; xd[1] = 1; yd[0] = -1;
        run_op("after_rst", 1'b0, -1, 0, -1, 1'b1, -96);

        // Spurious start during RUN, then start on the done cycle.
        rand_ops();
        run_op("spur", 1'b0, -1, 0, 2, 1'b0, 0);
        rand_ops();
        run_op("b2b", 1'b1, -1, 0, -1, 1'b0, 0);
        @(posedge clk); #1;
        chk("busy_after_done", busy, 0);

        // Randomized operations with random stalls and back-to-back starts.
        for (int t = 0; t < 12; t++) begin
            rand_ops();
            run_op("rnd", (t > 0) && ($urandom_range(0, 1) == 1), int'($urandom_range(0, N - 1)),
                   int'($urandom_range(0, 2)), -1, 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
